pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the five-stage core. Merges per-stage stall requests and the MEM-stage exception/redirect request into per-register `stall`/`flush` vectors for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Defers the PC redirect while an instruction fetch is still in flight. Also keeps a free-running stall-cycle counter for performance monitoring.

## Interface

Parameters:
- `RESET_PC`, default 32'hBFC0_0000: reset value of `redirect_pc`.

Ports:
- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `req_if`  in  1  fetch stage stall request.
- `req_id`  in  1  decode stage stall request.
- `req_ex`  in  1  execute stage stall request (mul/div multi-cycle).
- `req_mem`  in  1  memory stage stall request (D-side bus/cache).
- `if_busy`  in  1  I-side bus transaction outstanding; PC must not change.
- `exc_req`  in  1  MEM stage requests pipeline flush and redirect (exception/ERET).
- `exc_target`  in  32  redirect address, valid with `exc_req`.
- `stall`  out  5  hold enables. Bit 0 = PC, 1 = IF/ID, 2 = ID/EX, 3 = EX/MEM, 4 = MEM/WB.
- `flush`  out  5  bubble enables. Same bit order; bit 0 unused, always 0.
- `pc_redirect`  out  1  one-cycle pulse; PC loads `redirect_pc`.
- `redirect_pc`  out  32  redirect target.
- `stall_cnt`  out  32  count of cycles with any `stall`/`flush` bit set or FSM not in IDLE.

## Operation

Pipeline registers interpret `{flush, stall}` as follows:
- `1x`: bubble.
- `01`: hold.
- `00`: advance.

Stall decode (IDLE state, no accepted exception). The highest-index request wins:
- `req_mem`: `stall = 5'b01111`, `flush = 5'b10000`.
- else `req_ex`: `stall = 5'b00111`, `flush = 5'b01000`.
- else `req_id`: `stall = 5'b00011`, `flush = 5'b00100`.
- else `req_if`: `stall = 5'b00001`, `flush = 5'b00010`.
- else: both vectors 0.

Exception acceptance:
- Accepted in IDLE when `exc_req & ~req_mem`.
- While `req_mem` is high, `exc_req` is ignored; the MEM stage holds it until the stall clears.

On acceptance:
- `flush = 5'b11110`, `stall = 5'b00001`.
- `exc_target` is captured into the target register.
- If `if_busy == 0`: `pc_redirect = 1` and `redirect_pc = exc_target`, both combinationally in the same cycle. State stays IDLE.
- If `if_busy == 1`: next state is WAIT_IF.

WAIT_IF state:
- Outputs `flush = 5'b11110` and `stall = 5'b00001` every cycle.
- `redirect_pc` = captured target.
- In the first cycle with `if_busy == 0`: `pc_redirect = 1`, next state is IDLE.
- `exc_req` and all `req_*` inputs are ignored in WAIT_IF.

`redirect_pc` value:
- Driven from the captured target register whenever `pc_redirect` is 0.
- Retains the last target.

`stall_cnt`:
- Increments by 1 on each qualifying cycle.
- Wraps from 32'hFFFF_FFFF to 0.

## Timing

- Stall/flush decode is purely combinational from the `req_*` inputs and current state: zero-cycle latency.
- FSM state, target register and `stall_cnt` update on the rising edge of `clk`.
- Redirect latency:
  - 0 cycles when the fetch is idle.
  - Otherwise N cycles, where N is the number of cycles `if_busy` remains high after acceptance.
- Asynchronous reset (`resetn = 0`), effective immediately regardless of the clock:
  - state = IDLE
  - target = `RESET_PC`
  - `stall_cnt` = 0
  - `stall` = 0, `flush` = 0, `pc_redirect` = 0
  - `redirect_pc` = `RESET_PC`
- Reset asserted in WAIT_IF: the pending redirect is discarded.
- Simultaneous `exc_req` and `req_ex`/`req_id`/`req_if` (with `req_mem` low): the exception wins; stall decode is overridden.
- `exc_req` held high after acceptance in IDLE with a same-cycle redirect: accepted again the next cycle. The MEM stage drops `exc_req` once flushed; no deduplication is performed here.

## Test plan

- **Stall priority:** `req_if = req_ex = 1` → `stall = 00111`, `flush = 01000`; add `req_mem` → `stall = 01111`, `flush = 10000`.
- **Fast redirect:** `exc_req = 1`, `exc_target = 32'hBFC0_0380`, `if_busy = 0` → same cycle `flush = 11110`, `stall = 00001`, `pc_redirect = 1`, `redirect_pc = BFC0_0380`; state stays IDLE.
- **Deferred redirect:** `exc_req` with `if_busy = 1` for 3 cycles → 3 cycles of `flush = 11110` with no redirect, then 1 cycle with `pc_redirect = 1` and the captured target, then IDLE with outputs 0.
- **MEM-stall blocking:** `req_mem = 1` and `exc_req = 1` for 4 cycles → no flush of IF/ID, `pc_redirect = 0`; on the cycle `req_mem` drops, the exception is accepted.
- **Counter:** 5 stalled cycles plus 2 idle cycles → `stall_cnt = 5`. Force preload near wrap (bench `force`) to 32'hFFFF_FFFF, then 1 stall cycle → 0.
- **Reset mid-WAIT_IF:** deassert `resetn` while in WAIT_IF → all outputs 0, `redirect_pc = RESET_PC`; after `resetn = 1` with `if_busy = 0` → no `pc_redirect` pulse.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges stage stall requests and the MEM-stage
// exception into per-register stall/flush vectors, defers redirects behind I-fetch.
module pipe_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_if,
    input  logic        req_id,
    input  logic        req_ex,
    input  logic        req_mem,
    input  logic        if_busy,
    input  logic        exc_req,
    input  logic [31:0] exc_target,
    output logic [4:0]  stall,
    output logic [4:0]  flush,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] stall_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_WAIT_IF = 1'b1
    } state_t;

    state_t      state_r;
    logic [31:0] target_r;
    logic [31:0] stall_cnt_r;

    logic        accept_s;
    logic        active_s;
    logic [4:0]  stall_s;
    logic [4:0]  flush_s;
    logic        redirect_s;
    logic [31:0] redirect_pc_s;

    // Zero-latency stall/flush/redirect decode; outputs forced quiet while in reset.
    always_comb begin
        stall_s       = 5'b00000;
        flush_s       = 5'b00000;
        redirect_s    = 1'b0;
        redirect_pc_s = target_r;
        accept_s      = 1'b0;
        if (!resetn) begin
            stall_s    = 5'b00000;
            flush_s    = 5'b00000;
            redirect_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // A D-side stall masks the exception; MEM keeps presenting it.
                    accept_s = exc_req & ~req_mem;
                    if (accept_s) begin
                        stall_s = 5'b00001;
                        flush_s = 5'b11110;
                        if (!if_busy) begin
                            redirect_s    = 1'b1;
                            redirect_pc_s = exc_target;
                        end else begin
                            redirect_s = 1'b0;
                        end
                    end else if (req_mem) begin
                        stall_s = 5'b01111;
                        flush_s = 5'b10000;
                    end else if (req_ex) begin
                        stall_s = 5'b00111;
                        flush_s = 5'b01000;
                    end else if (req_id) begin
                        stall_s = 5'b00011;
                        flush_s = 5'b00100;
                    end else if (req_if) begin
                        stall_s = 5'b00001;
                        flush_s = 5'b00010;
                    end else begin
                        stall_s = 5'b00000;
                        flush_s = 5'b00000;
                    end
                end
                ST_WAIT_IF: begin
                    stall_s    = 5'b00001;
                    flush_s    = 5'b11110;
                    redirect_s = ~if_busy;
                end
                default: begin
                    stall_s    = 5'b00000;
                    flush_s    = 5'b00000;
                    redirect_s = 1'b0;
                end
            endcase
        end
    end

    assign active_s = (|stall_s) | (|flush_s) | (state_r != ST_IDLE);

    // Redirect FSM, captured target and free-running stall-cycle counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            target_r    <= RESET_PC;
            stall_cnt_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        target_r <= exc_target;
                        state_r  <= if_busy ? ST_WAIT_IF : ST_IDLE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT_IF: begin
                    if (!if_busy) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT_IF;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
            if (active_s) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign stall       = stall_s;
    assign flush       = flush_s;
    assign pc_redirect = redirect_s;
    assign redirect_pc = redirect_pc_s;
    assign stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: decode table, directed corner sequences,
// and randomized traffic against a rule-level reference model.
module tb_pipe_ctrl;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk;
    logic        resetn;
    logic        req_if, req_id, req_ex, req_mem;
    logic        if_busy, exc_req;
    logic [31:0] exc_target;
    logic [4:0]  stall, flush;
    logic        pc_redirect;
    logic [31:0] redirect_pc, stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending deferred redirect, last target, cycle count.
    logic        m_pending;
    logic [31:0] m_tgt;
    logic [31:0] m_cnt;
    logic        nx_pending;
    logic [31:0] nx_tgt;
    logic        nx_active;

    typedef struct {
        logic [3:0]  req;   // {mem, ex, id, if}
        logic        exc;
        logic [31:0] tgt;
        logic [4:0]  st;
        logic [4:0]  fl;
        logic        rd;
        logic [31:0] rpc;
    } vec_t;

    vec_t tbl [13];

    pipe_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .resetn(resetn),
        .req_if(req_if), .req_id(req_id), .req_ex(req_ex), .req_mem(req_mem),
        .if_busy(if_busy), .exc_req(exc_req), .exc_target(exc_target),
        .stall(stall), .flush(flush), .pc_redirect(pc_redirect),
        .redirect_pc(redirect_pc), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic e, input logic b, input logic [31:0] t);
        {req_mem, req_ex, req_id, req_if} = r;
        exc_req    = e;
        if_busy    = b;
        exc_target = t;
    endtask

    // Wait to the mid-cycle point, predict outputs from the rules, compare.
    task automatic settle();
        logic [4:0]  es, ef;
        logic        er;
        logic [31:0] erpc;
        int          s;
        @(negedge clk);
        es = 5'b0; ef = 5'b0; er = 1'b0; erpc = m_tgt;
        nx_pending = m_pending;
        nx_tgt     = m_tgt;
        if (m_pending || (exc_req && !req_mem)) begin
            es = 5'b00001;
            ef = 5'b11110;
            er = !if_busy;
            if (!m_pending) begin
                nx_tgt = exc_target;
                if (!if_busy) erpc = exc_target;
            end
            nx_pending = if_busy;
        end else begin
            s = 0;
            if (req_if)  s = 1;
            if (req_id)  s = 2;
            if (req_ex)  s = 3;
            if (req_mem) s = 4;
            for (int i = 0; i < s; i++) es[i] = 1'b1;
            if (s > 0) ef[s] = 1'b1;
        end
        nx_active = (es != 5'b0) || (ef != 5'b0) || m_pending;
        check("stall", {27'd0, stall}, {27'd0, es});
        check("flush", {27'd0, flush}, {27'd0, ef});
        check("pc_redirect", {31'd0, pc_redirect}, {31'd0, er});
        check("redirect_pc", redirect_pc, erpc);
        check("stall_cnt", stall_cnt, m_cnt);
    endtask

    task automatic advance();
        @(posedge clk);
        m_pending = nx_pending;
        m_tgt     = nx_tgt;
        if (nx_active) m_cnt = m_cnt + 32'd1;
        #1;
    endtask

    task automatic step(input logic [3:0] r, input logic e, input logic b, input logic [31:0] t);
        drive(r, e, b, t);
        settle();
        advance();
    endtask

    // Asynchronous reset mid-cycle with busy inputs; outputs must go quiet at once.
    task automatic do_reset();
        drive(4'b1111, 1'b1, 1'b1, 32'h5555_AAAA);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_stall", {27'd0, stall}, 32'd0);
        check("rst_flush", {27'd0, flush}, 32'd0);
        check("rst_redirect", {31'd0, pc_redirect}, 32'd0);
        check("rst_redirect_pc", redirect_pc, RST_PC);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        m_pending = 1'b0;
        m_tgt     = RST_PC;
        m_cnt     = 32'd0;
        @(posedge clk);
        #1;
        drive(4'b0000, 1'b0, 1'b0, 32'd0);
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b1;
        drive(4'b0000, 1'b0, 1'b0, 32'd0);
        #2;
        do_reset();

        tbl[0]  = '{4'b0000, 1'b0, 32'h0,         5'b00000, 5'b00000, 1'b0, RST_PC};
        tbl[1]  = '{4'b0001, 1'b0, 32'h0,         5'b00001, 5'b00010, 1'b0, RST_PC};
        tbl[2]  = '{4'b0010, 1'b0, 32'h0,         5'b00011, 5'b00100, 1'b0, RST_PC};
        tbl[3]  = '{4'b0100, 1'b0, 32'h0,         5'b00111, 5'b01000, 1'b0, RST_PC};
        tbl[4]  = '{4'b1000, 1'b0, 32'h0,         5'b01111, 5'b10000, 1'b0, RST_PC};
        tbl[5]  = '{4'b0101, 1'b0, 32'h0,         5'b00111, 5'b01000, 1'b0, RST_PC};
        tbl[6]  = '{4'b1101, 1'b0, 32'h0,         5'b01111, 5'b10000, 1'b0, RST_PC};
        tbl[7]  = '{4'b0011, 1'b0, 32'h0,         5'b00011, 5'b00100, 1'b0, RST_PC};
        tbl[8]  = '{4'b1111, 1'b0, 32'h0,         5'b01111, 5'b10000, 1'b0, RST_PC};
        tbl[9]  = '{4'b0000, 1'b1, 32'hBFC0_0380, 5'b00001, 5'b11110, 1'b1, 32'hBFC0_0380};
        tbl[10] = '{4'b0111, 1'b1, 32'h1234_5678, 5'b00001, 5'b11110, 1'b1, 32'h1234_5678};
        tbl[11] = '{4'b1000, 1'b1, 32'hDEAD_BEEF, 5'b01111, 5'b10000, 1'b0, 32'h1234_5678};
        tbl[12] = '{4'b0000, 1'b0, 32'hCAFE_0000, 5'b00000, 5'b00000, 1'b0, 32'h1234_5678};

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].req, tbl[i].exc, 1'b0, tbl[i].tgt);
            settle();
            check($sformatf("tbl%0d_stall", i), {27'd0, stall}, {27'd0, tbl[i].st});
            check($sformatf("tbl%0d_flush", i), {27'd0, flush}, {27'd0, tbl[i].fl});
            check($sformatf("tbl%0d_redir", i), {31'd0, pc_redirect}, {31'd0, tbl[i].rd});
            check($sformatf("tbl%0d_rpc", i), redirect_pc, tbl[i].rpc);
            advance();
        end

        // Deferred redirect: fetch busy for 3 cycles after acceptance.
        step(4'b0000, 1'b1, 1'b1, 32'h8000_0180);
        step(4'b1111, 1'b1, 1'b1, 32'h0000_1111);
        step(4'b0000, 1'b0, 1'b1, 32'h0);
        drive(4'b0000, 1'b0, 1'b0, 32'h0);
        settle();
        check("defer_redirect", {31'd0, pc_redirect}, 32'd1);
        check("defer_target", redirect_pc, 32'h8000_0180);
        advance();
        step(4'b0000, 1'b0, 1'b0, 32'h0);

        // MEM stall blocks the exception until it drops.
        for (int i = 0; i < 4; i++) begin
            drive(4'b1000, 1'b1, 1'b0, 32'hBFC0_0200);
            settle();
            check("memblk_ifid", {31'd0, flush[1]}, 32'd0);
            advance();
        end
        step(4'b0000, 1'b1, 1'b0, 32'hBFC0_0200);

        // Counter: 5 stalled + 2 idle cycles, then wrap.
        do_reset();
        for (int i = 0; i < 5; i++) step(4'b0010, 1'b0, 1'b0, 32'h0);
        step(4'b0000, 1'b0, 1'b0, 32'h0);
        step(4'b0000, 1'b0, 1'b0, 32'h0);
        check("cnt_five", stall_cnt, 32'd5);
        force dut.stall_cnt_r = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_r;
        m_cnt = 32'hFFFF_FFFF;
        step(4'b0001, 1'b0, 1'b0, 32'h0);
        check("cnt_wrap", stall_cnt, 32'd0);

        // Reset while a redirect is pending discards it.
        step(4'b0000, 1'b1, 1'b1, 32'h0BAD_0BAD);
        step(4'b0000, 1'b0, 1'b1, 32'h0);
        do_reset();
        drive(4'b0000, 1'b0, 1'b0, 32'h0);
        settle();
        check("post_rst_no_redirect", {31'd0, pc_redirect}, 32'd0);
        advance();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [3:0] r;
            r[0] = ($urandom_range(0, 3) == 0);
            r[1] = ($urandom_range(0, 3) == 0);
            r[2] = ($urandom_range(0, 3) == 0);
            r[3] = ($urandom_range(0, 4) == 0);
            step(r, ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 1), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
